// File: rtl/alu_driver.sv
// alu_driver: byte-stream command sequencer for an external ALU (define ALU_DRV_OPCHECK_EN to reject illegal opcodes)
module alu_driver #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] IN_DATA,
  input  logic       IN_VALID,
  output logic       IN_READY,
  output logic [7:0] ALU_A,
  output logic [7:0] ALU_B,
  output logic [3:0] ALU_SEL,
  input  logic [7:0] ALU_RES,
  input  logic [3:0] ALU_FLAGS,
  output logic [7:0] RES_DATA,
  output logic [3:0] RES_FLAGS,
  output logic       RES_ERR,
  output logic       RES_VALID,
  input  logic       RES_READY,
  output logic [7:0] CMD_CNT,
  output logic       BUSY
);
`ifdef ALU_DRV_OPCHECK_EN
  localparam bit OPCHECK = 1'b1;
`else
  localparam bit OPCHECK = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, GET_A, GET_B, EXEC, SEND} state_t;
  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] a_q, a_d, b_q, b_d, res_q, res_d, cmd_q, cmd_d;
  logic [3:0] sel_q, sel_d, flags_q, flags_d;
  logic       err_q, err_d, valid_q, valid_d, bad_q, bad_d;
  logic       in_xfer, op_bad, last;
  assign IN_READY  = state_q inside {IDLE, GET_A, GET_B};
  assign BUSY      = state_q != IDLE;
  assign ALU_A     = a_q;
  assign ALU_B     = b_q;
  assign ALU_SEL   = sel_q;
  assign RES_DATA  = res_q;
  assign RES_FLAGS = flags_q;
  assign RES_ERR   = OPCHECK & err_q;
  assign RES_VALID = valid_q;
  assign CMD_CNT   = cmd_q;
  assign in_xfer   = IN_VALID & IN_READY;
  assign op_bad    = OPCHECK & ((IN_DATA[7:4] != 4'h0) | (IN_DATA[3:0] > 4'hB));
  assign last      = cnt_q == 2'(EXEC_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    res_d   = res_q;
    flags_d = flags_q;
    err_d   = err_q;
    valid_d = valid_q;
    cmd_d   = cmd_q;
    bad_d   = bad_q;
    case (state_q)
      IDLE: if (in_xfer) begin
        bad_d   = op_bad;
        sel_d   = op_bad ? sel_q : IN_DATA[3:0];
        state_d = GET_A;
      end
      GET_A: if (in_xfer) begin
        a_d     = IN_DATA;
        state_d = GET_B;
      end
      GET_B: if (in_xfer) begin
        b_d     = IN_DATA;
        cnt_d   = 2'd0;
        res_d   = bad_q ? 8'h00 : res_q;
        flags_d = bad_q ? 4'h0 : flags_q;
        err_d   = bad_q ? 1'b1 : err_q;
        valid_d = bad_q;
        state_d = bad_q ? SEND : EXEC;
      end
      EXEC: if (last) begin
        res_d   = ALU_RES;
        flags_d = ALU_FLAGS;
        err_d   = 1'b0;
        valid_d = 1'b1;
        state_d = SEND;
      end else begin
        cnt_d   = cnt_q + 2'd1;
      end
      SEND: if (RES_READY) begin
        valid_d = 1'b0;
        cmd_d   = cmd_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      sel_q   <= 4'h0;
      res_q   <= 8'h00;
      flags_q <= 4'h0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      cmd_q   <= 8'h00;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
      bad_q   <= bad_d;
    end
  end
endmodule
